// File: rtl/jump_control.sv
// jump_control: control-flow decoder upstream of the program counter.
// Evaluates JMP/BEQ/BNE/CALL/RET, drives the PC jump request (write/salto),
// keeps a small return-address stack and raises flush after every taken jump.
// Optional build macro JUMP_CONTROL_STATS_EN adds an 8-bit saturating
// taken_count output.
module jump_control #(
   parameter int unsigned ADDR_W       = 6,
   parameter int unsigned STACK_DEPTH  = 4,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] alvo,
   input  logic [ADDR_W-1:0] endereco_atual,
   input  logic              flag_zero,
   output logic              write,
   output logic [ADDR_W-1:0] salto,
   output logic              flush,
   output logic              stack_overflow,
   output logic              stack_underflow
`ifdef JUMP_CONTROL_STATS_EN
   ,
   output logic [7:0]        taken_count
`endif
);

   localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;
   localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [2:0] {
      OP_NONE = 3'b000,
      OP_JMP  = 3'b001,
      OP_BEQ  = 3'b010,
      OP_BNE  = 3'b011,
      OP_CALL = 3'b100,
      OP_RET  = 3'b101
   } op_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [PTR_W-1:0]  ptr;
   logic [ADDR_W-1:0] stack [STACK_DEPTH];
   logic [IDX_W-1:0]  push_idx, pop_idx;
   logic              full, empty;
   logic              take, do_push, do_pop, ovf_set, unf_set;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] ret_addr;

   assign push_idx = ptr[IDX_W-1:0];
   assign pop_idx  = push_idx - IDX_W'(1);
   assign full     = (ptr == PTR_W'(STACK_DEPTH));
   assign empty    = (ptr == '0);
   assign ret_addr = endereco_atual + ADDR_W'(1);
   assign flush    = (state == FLUSH);

   // Decode the opcode in RUN; count down the flush window in FLUSH.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      take     = 1'b0;
      target   = alvo;
      do_push  = 1'b0;
      do_pop   = 1'b0;
      ovf_set  = 1'b0;
      unf_set  = 1'b0;
      case (state)
         RUN: begin
            case (op)
               OP_JMP: take = 1'b1;
               OP_BEQ: take = flag_zero;
               OP_BNE: take = !flag_zero;
               OP_CALL: begin
                  if (!full) begin
                     take    = 1'b1;
                     do_push = 1'b1;
                  end else begin
                     ovf_set = 1'b1;
                  end
               end
               OP_RET: begin
                  if (!empty) begin
                     take   = 1'b1;
                     do_pop = 1'b1;
                     target = stack[pop_idx];
                  end else begin
                     unf_set = 1'b1;
                  end
               end
               default: ;
            endcase
            if (take) begin
               state_nx = FLUSH;
               cnt_nx   = CNT_W'(FLUSH_CYCLES);
            end
         end
         FLUSH: begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_nx = RUN;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   // State, flush counter, jump request, stack pointer and sticky flags.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state           <= RUN;
         cnt             <= '0;
         write           <= 1'b0;
         salto           <= '0;
         ptr             <= '0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         write <= take;
         if (take) begin
            salto <= target;
         end
         if (do_push) begin
            ptr <= ptr + PTR_W'(1);
         end else if (do_pop) begin
            ptr <= ptr - PTR_W'(1);
         end
         if (ovf_set) begin
            stack_overflow <= 1'b1;
         end
         if (unf_set) begin
            stack_underflow <= 1'b1;
         end
      end
   end

   // Return-address storage; only the pointer needs reset to empty the stack.
   always_ff @(posedge clock) begin
      if (do_push) begin
         stack[push_idx] <= ret_addr;
      end
   end

`ifdef JUMP_CONTROL_STATS_EN
   // Saturating count of taken control-flow decisions.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         taken_count <= '0;
      end else if (take && taken_count != 8'hFF) begin
         taken_count <= taken_count + 8'd1;
      end
   end
`endif

endmodule
